// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ byte producers. Grants are round-robin
// and last for a whole packet (until req_last). Bytes reach uart_tx through a
// one-entry output register that supports back-to-back loads.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN - releases a grant whose
// owner stays idle mid-packet for TIMEOUT_CYC cycles and pulses arb_timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 2700
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_data_valid,
   input  logic                   tx_data_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   arb_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE = 2'b01,
      LOCK = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_found;
   logic [7:0]       own_data;
   logic             own_valid;
   logic             own_last;
   logic             out_ready;
   logic             accept;
   logic             accept_last;
   logic             timeout_hit;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
   end

   // Round-robin scan starting after last_grant; walking the offsets from far
   // to near lets the nearest valid requester overwrite the others.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Byte of the current owner, selected by the one-hot grant.
   always_comb begin
      own_data = 8'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            own_data = req_data[i*8 +: 8];
         end
      end
   end

   assign own_valid   = |(req_valid & grant);
   assign own_last    = |(req_last & grant);
   assign out_ready   = ~tx_data_valid | tx_data_ready;
   assign accept      = (state == LOCK) & own_valid & out_ready;
   assign accept_last = accept & own_last;

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: lock on a winner, release on the last byte or a timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_found) state_next = LOCK;
         LOCK:    if (accept_last || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: only the owner sees ready, and only when the output register can take a byte.
   always_comb begin
      req_ready = '0;
      if (state == LOCK) begin
         req_ready = grant & {NUM_REQ{out_ready}};
      end
      busy = (state == LOCK) | tx_data_valid;
   end

   // Grant and round-robin pointer; the pointer only moves when a grant is released.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         grant      <= '0;
         grant_idx  <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant     <= NUM_REQ'(1) << win_idx;
                  grant_idx <= win_idx;
               end else begin
                  grant <= '0;
               end
            end
            LOCK: begin
               if (accept_last || timeout_hit) begin
                  grant      <= '0;
                  last_grant <= grant_idx;
               end
            end
            default: grant <= '0;
         endcase
      end
   end

   // One-entry output register: a load wins over a drain so bytes can stream back-to-back.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_data       <= 8'd0;
         tx_data_valid <= 1'b0;
      end else if (accept) begin
         tx_data       <= own_data;
         tx_data_valid <= 1'b1;
      end else if (tx_data_ready) begin
         tx_data_valid <= 1'b0;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [31:0] idle_cnt;

   assign timeout_hit = (state == LOCK) & ~own_valid & (idle_cnt == 32'(TIMEOUT_CYC - 1));

   // Counts owner-idle cycles inside a packet; the pulse marks the forced release.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idle_cnt    <= 32'd0;
         arb_timeout <= 1'b0;
      end else begin
         arb_timeout <= timeout_hit;
         if ((state != LOCK) || own_valid || timeout_hit) begin
            idle_cnt <= 32'd0;
         end else begin
            idle_cnt <= idle_cnt + 32'd1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter: a cycle table with hand-computed
// expectations, then requester/uart_tx sequences for the multi-cycle cases.
// Build with UART_TX_ARB_TIMEOUT_EN defined to also exercise the timeout.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 3;
   localparam int TIMEOUT_CYC = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int GAP_CYC = 10;
`else
   localparam int GAP_CYC = 20;
`endif

   logic                 sys_clk = 1'b0;
   logic                 sys_rst_n;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_data_valid;
   logic                 tx_data_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 arb_timeout;

   uart_tx_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .grant         (grant),
      .busy          (busy),
      .arb_timeout   (arb_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [2:0]  valid;
      logic [2:0]  last;
      logic [23:0] data;
      logic        txReady;
      logic [2:0]  expGrant;
      logic [2:0]  expReady;
      logic        expValid;
      logic [7:0]  expData;
      logic        expBusy;
   } vector_t;

   vector_t            vecs [17];
   int                 assertCount = 0;
   int                 failCount   = 0;
   logic [8:0]         reqQ [NUM_REQ][$];
   logic [7:0]         rxQ [$];
   logic [NUM_REQ-1:0] holdMask;
   int                 readyPeriod;
   logic               readyLevel;
   int                 cycleCount;
   logic               tblFire;
   logic [7:0]         tblByte;
   logic               flagA;
   logic               flagB;
   logic               flagC;
   int                 pulseEdge;
   int                 grantEdge;
   int                 pulses;
   int                 n;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vector_t v);
      req_valid     = v.valid;
      req_last      = v.last;
      req_data      = v.data;
      tx_data_ready = v.txReady;
   endtask

   function automatic logic anyQueued();
      logic q = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reqQ[i].size() > 0) q = 1'b1;
      end
      return q;
   endfunction

   // Queue a packet for requester r; bytes[8*(cnt-1) +: 8] goes first, last flag on the final byte.
   task automatic loadPacket(input int r, input int cnt, input logic [63:0] bytes);
      for (int i = 0; i < cnt; i++) begin
         reqQ[r].push_back({(i == cnt - 1), bytes[8*(cnt-1-i) +: 8]});
      end
   endtask

   // One clock of requester + uart_tx models; returns #1 after the active edge.
   task automatic bfmCycle();
      logic [NUM_REQ-1:0] fire;
      logic               txFire;
      logic [7:0]         txByte;
      @(negedge sys_clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reqQ[i].size() > 0 && !holdMask[i]) begin
            req_valid[i]        = 1'b1;
            req_last[i]         = reqQ[i][0][8];
            req_data[i*8 +: 8]  = reqQ[i][0][7:0];
         end else begin
            req_valid[i]        = 1'b0;
            req_last[i]         = 1'b0;
            req_data[i*8 +: 8]  = 8'h00;
         end
      end
      if (readyPeriod == 0) tx_data_ready = readyLevel;
      else tx_data_ready = ((cycleCount % readyPeriod) == readyPeriod - 1);
      #1;
      fire   = req_valid & req_ready;
      txFire = tx_data_valid & tx_data_ready;
      txByte = tx_data;
      @(posedge sys_clk);
      #1;
      if (txFire) rxQ.push_back(txByte);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (fire[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
      end
      cycleCount++;
   endtask

   task automatic waitIdle(input string name, input int bound);
      int c = 0;
      while ((anyQueued() || busy) && c < bound) begin
         bfmCycle();
         c++;
      end
      checkOutput({name, " finished in budget"}, (anyQueued() || busy), 1'b0);
   endtask

   // Compare captured uart_tx bytes with cnt expected bytes, first byte most significant.
   task automatic checkRx(input string name, input int cnt, input logic [63:0] bytes);
      checkOutput({name, " byte count"}, rxQ.size(), cnt);
      for (int i = 0; i < cnt; i++) begin
         if (i < rxQ.size()) begin
            checkOutput($sformatf("%s byte%0d", name, i), rxQ[i], bytes[8*(cnt-1-i) +: 8]);
         end
      end
   endtask

   task automatic applyReset();
      sys_rst_n     = 1'b0;
      req_valid     = '0;
      req_last      = '0;
      req_data      = '0;
      tx_data_ready = 1'b0;
      holdMask      = '0;
      readyPeriod   = 0;
      readyLevel    = 1'b1;
      cycleCount    = 0;
      for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
      rxQ.delete();
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " grant"},         grant,         3'b000);
      checkOutput({name, " req_ready"},     req_ready,     3'b000);
      checkOutput({name, " tx_data"},       tx_data,       8'h00);
      checkOutput({name, " tx_data_valid"}, tx_data_valid, 1'b0);
      checkOutput({name, " busy"},          busy,          1'b0);
      checkOutput({name, " arb_timeout"},   arb_timeout,   1'b0);
   endtask

   initial begin
      // valid last data{d2,d1,d0} txReady | grant ready txValid txData busy
      vecs[0]  = '{3'b100, 3'b000, 24'h310000, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{3'b100, 3'b000, 24'h310000, 1'b1, 3'b100, 3'b100, 1'b0, 8'h00, 1'b1};
      vecs[2]  = '{3'b100, 3'b000, 24'h320000, 1'b1, 3'b100, 3'b100, 1'b1, 8'h31, 1'b1};
      vecs[3]  = '{3'b100, 3'b000, 24'h330000, 1'b1, 3'b100, 3'b100, 1'b1, 8'h32, 1'b1};
      vecs[4]  = '{3'b100, 3'b000, 24'h340000, 1'b1, 3'b100, 3'b100, 1'b1, 8'h33, 1'b1};
      vecs[5]  = '{3'b100, 3'b100, 24'h350000, 1'b1, 3'b100, 3'b100, 1'b1, 8'h34, 1'b1};
      vecs[6]  = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b1, 8'h35, 1'b1};
      vecs[7]  = '{3'b001, 3'b001, 24'h000055, 1'b0, 3'b000, 3'b000, 1'b0, 8'h35, 1'b0};
      vecs[8]  = '{3'b001, 3'b001, 24'h000055, 1'b0, 3'b001, 3'b001, 1'b0, 8'h35, 1'b1};
      vecs[9]  = '{3'b011, 3'b011, 24'h006677, 1'b0, 3'b000, 3'b000, 1'b1, 8'h55, 1'b1};
      vecs[10] = '{3'b011, 3'b011, 24'h006677, 1'b0, 3'b010, 3'b000, 1'b1, 8'h55, 1'b1};
      vecs[11] = '{3'b011, 3'b011, 24'h006677, 1'b1, 3'b010, 3'b010, 1'b1, 8'h55, 1'b1};
      vecs[12] = '{3'b001, 3'b001, 24'h000077, 1'b1, 3'b000, 3'b000, 1'b1, 8'h66, 1'b1};
      vecs[13] = '{3'b001, 3'b001, 24'h000077, 1'b0, 3'b001, 3'b001, 1'b0, 8'h66, 1'b1};
      vecs[14] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 3'b000, 1'b1, 8'h77, 1'b1};
      vecs[15] = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b1, 8'h77, 1'b1};
      vecs[16] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 3'b000, 1'b0, 8'h77, 1'b0};

      sys_rst_n     = 1'b1;
      req_valid     = '0;
      req_last      = '0;
      req_data      = '0;
      tx_data_ready = 1'b0;
      holdMask      = '0;
      readyPeriod   = 0;
      readyLevel    = 1'b1;
      cycleCount    = 0;
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkResetValues("reset");
      applyReset();

      // Back-to-back stream from req 2, single-byte packets, turnaround and fairness.
      for (int v = 0; v < 17; v++) begin
         @(negedge sys_clk);
         applyStimulus(vecs[v]);
         #1;
         checkOutput($sformatf("vec%0d grant", v),         grant,         vecs[v].expGrant);
         checkOutput($sformatf("vec%0d req_ready", v),     req_ready,     vecs[v].expReady);
         checkOutput($sformatf("vec%0d tx_data_valid", v), tx_data_valid, vecs[v].expValid);
         checkOutput($sformatf("vec%0d tx_data", v),       tx_data,       vecs[v].expData);
         checkOutput($sformatf("vec%0d busy", v),          busy,          vecs[v].expBusy);
         tblFire = tx_data_valid & tx_data_ready;
         tblByte = tx_data;
         @(posedge sys_clk);
         #1;
         if (tblFire) rxQ.push_back(tblByte);
      end
      checkRx("table", 8, 64'h3132333435556677);

      // Single requester with a slow uart_tx.
      applyReset();
      loadPacket(1, 4, 64'h48690D0A);
      readyPeriod = 10;
      bfmCycle();
      checkOutput("single grant N+1", grant, 3'b010);
      checkOutput("single req_ready N+1", req_ready, 3'b010);
      bfmCycle();
      checkOutput("single tx_data N+2", tx_data, 8'h48);
      checkOutput("single tx_data_valid N+2", tx_data_valid, 1'b1);
      waitIdle("single", 200);
      checkRx("single", 4, 64'h48690D0A);
      checkOutput("single grant end", grant, 3'b000);
      checkOutput("single busy end", busy, 1'b0);

      // Contention from reset: packets in order 0,1,2 without interleaving.
      applyReset();
      loadPacket(0, 2, 64'h00A0);
      loadPacket(1, 2, 64'h01A1);
      loadPacket(2, 2, 64'h02A2);
      waitIdle("contention", 100);
      checkRx("contention", 6, 64'h00A001A102A2);

      // Mid-packet gap with a competitor waiting, then a long uart_tx stall.
      applyReset();
      loadPacket(0, 4, 64'h10111213);
      loadPacket(1, 2, 64'h2021);
      repeat (3) bfmCycle();
      checkOutput("gap setup grant", grant, 3'b001);
      checkOutput("gap setup tx_data", tx_data, 8'h11);
      holdMask = 3'b001;
      flagA = 1'b1;
      flagB = 1'b1;
      flagC = 1'b1;
      for (int c = 0; c < GAP_CYC; c++) begin
         bfmCycle();
         if (grant !== 3'b001) flagA = 1'b0;
         if (req_ready[1] !== 1'b0) flagB = 1'b0;
         if (arb_timeout !== 1'b0) flagC = 1'b0;
      end
      checkOutput("gap grant held", flagA, 1'b1);
      checkOutput("gap other not ready", flagB, 1'b1);
      checkOutput("gap no timeout", flagC, 1'b1);
      holdMask   = '0;
      readyLevel = 1'b0;
      flagA = 1'b1;
      flagB = 1'b1;
      for (int c = 0; c < 50; c++) begin
         bfmCycle();
         if (tx_data !== 8'h12 || tx_data_valid !== 1'b1) flagA = 1'b0;
         if (grant !== 3'b001) flagB = 1'b0;
      end
      checkOutput("stall tx_data held", flagA, 1'b1);
      checkOutput("stall grant held", flagB, 1'b1);
      readyLevel = 1'b1;
      waitIdle("gap", 100);
      checkRx("gap", 6, 64'h101112132021);

      // Reset mid-packet, then req 0 must win against req 1.
      applyReset();
      loadPacket(0, 1, 64'h40);
      loadPacket(1, 4, 64'h41424344);
      n = 0;
      while (rxQ.size() < 3 && n < 50) begin
         bfmCycle();
         n++;
      end
      checkOutput("midreset progress", (rxQ.size() >= 3), 1'b1);
      checkOutput("midreset busy before", busy, 1'b1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      applyReset();
      loadPacket(0, 1, 64'h50);
      loadPacket(1, 1, 64'h60);
      bfmCycle();
      checkOutput("after reset first grant", grant, 3'b001);
      waitIdle("after reset", 100);
      checkRx("after reset", 2, 64'h5060);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Owner stalls mid-packet: forced release after TIMEOUT_CYC idle cycles.
      applyReset();
      reqQ[1].push_back(9'h070);
      loadPacket(2, 1, 64'h80);
      pulseEdge = -1;
      grantEdge = -1;
      pulses    = 0;
      for (int e = 0; e < 40; e++) begin
         bfmCycle();
         if (arb_timeout === 1'b1) begin
            pulses++;
            if (pulseEdge < 0) pulseEdge = e;
         end
         if (grant === 3'b100 && grantEdge < 0) grantEdge = e;
      end
      checkOutput("timeout pulse cycle", pulseEdge, 17);
      checkOutput("timeout pulse width", pulses, 1);
      checkOutput("timeout next grant cycle", grantEdge, 18);
      waitIdle("timeout", 100);
      checkRx("timeout", 2, 64'h7080);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
